// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC result UART stage
package cordic_pkg;
  localparam int VAL_W = 11;
  localparam logic [4:0] SYNC_PAT = 5'b10100;
  localparam int CLK_DIV_DEF = 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/cordic_uart_tx_if.sv
// cordic_uart_tx_if: result bus from the CORDIC core plus UART status/pin outputs
interface cordic_uart_tx_if #(parameter int DEPTH = 2);
  logic [cordic_pkg::VAL_W-1:0] val;
  logic done;
  logic tx;
  logic busy;
  logic overflow;
  logic [$clog2(DEPTH):0] level;
  modport master(output val, done, input tx, busy, overflow, level);
  modport slave(input val, done, output tx, busy, overflow, level);
endinterface

// File: rtl/cordic_result_fifo.sv
// cordic_result_fifo: DEPTH x W synchronous FIFO; push accepted when full if a pop happens too
module cordic_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 11,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic empty,
  output logic full,
  output logic [AW:0] level
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_push, do_pop;
  assign level = wp_q - rp_q;
  assign empty = level == '0;
  assign full = level[AW];
  assign dout = mem_q[rp_q[AW-1:0]];
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  // pointer advance; the extra MSB distinguishes full from empty
  always_comb begin
    wp_d = wp_q + {{AW{1'b0}}, do_push};
    rp_d = rp_q + {{AW{1'b0}}, do_pop};
  end
  // pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // storage; a slot being popped can be overwritten in the same cycle since dout is read first
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cordic_uart_tx.sv
// cordic_uart_tx: captures CORDIC results on done rising edge and sends each as two UART 8N1 bytes
module cordic_uart_tx #(
  parameter int CLK_DIV = cordic_pkg::CLK_DIV_DEF,
  parameter int DEPTH = 2,
  parameter int VAL_W = cordic_pkg::VAL_W
) (
  input logic clk,
  input logic rst,
  cordic_uart_tx_if.slave bus
);
  import cordic_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] RELOAD = BW'(CLK_DIV - 1);
  tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [VAL_W-1:0] hold_q, hold_d, dout;
  logic [AW:0] level;
  logic [7:0] cur_byte;
  logic byte_sel_q, byte_sel_d, tx_q, tx_d, done_q, overflow_q, overflow_d;
  logic push, pop, empty, full, tick;
  assign push = bus.done & ~done_q;
  assign tick = baud_q == '0;
  assign cur_byte = byte_sel_q ? hold_q[7:0] : {SYNC_PAT, hold_q[VAL_W-1:8]};
  assign bus.tx = tx_q;
  assign bus.busy = (state_q != IDLE) | (level != '0);
  assign bus.overflow = overflow_q;
  assign bus.level = level;
  cordic_result_fifo #(.DEPTH(DEPTH), .W(VAL_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(bus.val),
    .dout(dout), .empty(empty), .full(full), .level(level)
  );
  // next-state: frame sequencing, baud reload on every bit boundary, FIFO pop
  always_comb begin
    state_d = state_q;
    baud_d = baud_q - 1'b1;
    bit_idx_d = bit_idx_q;
    byte_sel_d = byte_sel_q;
    hold_d = hold_q;
    tx_d = tx_q;
    pop = 1'b0;
    overflow_d = overflow_q | (push & full & ~pop);
    case (state_q)
      IDLE: begin
        baud_d = RELOAD;
        tx_d = 1'b1;
        if (!empty) begin
          pop = 1'b1;
          hold_d = dout;
          byte_sel_d = 1'b0;
          state_d = START;
          tx_d = 1'b0;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_idx_d = '0;
        baud_d = RELOAD;
        tx_d = cur_byte[0];
      end
      DATA: if (tick) begin
        baud_d = RELOAD;
        state_d = bit_idx_q == 3'd7 ? STOP : DATA;
        bit_idx_d = bit_idx_q + 3'd1;
        tx_d = bit_idx_q == 3'd7 ? 1'b1 : cur_byte[bit_idx_q + 3'd1];
      end
      STOP: if (tick) begin
        baud_d = RELOAD;
        state_d = START;
        tx_d = 1'b0;
        if (!byte_sel_q) byte_sel_d = 1'b1;
        else if (!empty) begin
          pop = 1'b1;
          hold_d = dout;
          byte_sel_d = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d = 1'b1;
        end
      end
    endcase
    overflow_d = overflow_q | (push & full & ~pop);
  end
  // state registers; reset forces the pin idle and abandons any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_idx_q <= '0;
      byte_sel_q <= 1'b0;
      hold_q <= '0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_idx_q <= bit_idx_d;
      byte_sel_q <= byte_sel_d;
      hold_q <= hold_d;
      tx_q <= tx_d;
      done_q <= bus.done;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_cordic_uart_tx.sv
// tb_cordic_uart_tx: directed checks of capture, framing, FIFO overflow and reset for cordic_uart_tx
module tb_cordic_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] b, bs [6], cs [2], ds [2];
  int g, gs [6], maxl;
  logic q;
  logic [7:0] e3 [6] = '{8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA3, 8'h00};
  logic [7:0] e4 [6] = '{8'hA1, 8'h23, 8'hA4, 8'h56, 8'hA7, 8'hFF};
  always #5 clk = ~clk;
  cordic_uart_tx_if #(.DEPTH(2)) ia();
  cordic_uart_tx_if #(.DEPTH(2)) ib();
  cordic_uart_tx_if #(.DEPTH(2)) ic();
  cordic_uart_tx #(.CLK_DIV(4), .DEPTH(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  cordic_uart_tx #(.CLK_DIV(2), .DEPTH(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  cordic_uart_tx #(.CLK_DIV(16), .DEPTH(2)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rx(input int w);
    return w == 0 ? ia.tx : w == 1 ? ib.tx : ic.tx;
  endfunction

  task automatic recv(input int w, input int div, output logic [7:0] d, output int gap);
    int n = 0;
    logic ok = 1'b1;
    logic v;
    d = '0;
    do begin
      @(negedge clk);
      n++;
    end while (rx(w) !== 1'b0 && n < 2000);
    gap = n;
    if (n >= 2000) begin
      chk("start_timeout", 32'(n), 0);
      return;
    end
    for (int k = 1; k < div; k++) begin
      @(negedge clk);
      if (rx(w) !== 1'b0) ok = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = rx(w);
      d[i] = v;
      for (int k = 1; k < div; k++) begin
        @(negedge clk);
        if (rx(w) !== v) ok = 1'b0;
      end
    end
    for (int k = 0; k < div; k++) begin
      @(negedge clk);
      if (rx(w) !== 1'b1) ok = 1'b0;
    end
    chk("bit_timing", ok, 1);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    ia.done = 1'b0;
    ib.done = 1'b0;
    ic.done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [10:0] v);
    @(negedge clk);
    ia.val = v;
    ia.done = 1'b1;
    @(negedge clk);
    ia.done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ia.val = '0;
    ib.val = '0;
    ic.val = '0;
    reset_all();
    chk("rst_tx", ia.tx, 1);
    chk("rst_busy", ia.busy, 0);
    chk("rst_ovf", ia.overflow, 0);
    chk("rst_level", ia.level, 0);
    // single result 0x5A3 -> A5, A3
    pulse(11'h5A3);
    chk("cap_level", ia.level, 1);
    chk("cap_tx_idle", ia.tx, 1);
    recv(0, 4, b, g);
    chk("t1_latency", g, 1);
    chk("t1_byte0", b, 8'hA5);
    recv(0, 4, b, g);
    chk("t1_gap", g, 1);
    chk("t1_byte1", b, 8'hA3);
    @(negedge clk);
    chk("t1_end_tx", ia.tx, 1);
    chk("t1_end_busy", ia.busy, 0);
    // done held high for 100 cycles -> exactly one frame
    maxl = 0;
    fork
      begin
        @(negedge clk);
        ia.val = 11'h001;
        ia.done = 1'b1;
        repeat (100) begin
          @(negedge clk);
          if (ia.level > maxl) maxl = ia.level;
        end
        ia.done = 1'b0;
      end
      begin
        recv(0, 4, bs[0], gs[0]);
        recv(0, 4, bs[1], gs[1]);
      end
    join
    chk("t2_byte0", bs[0], 8'hA0);
    chk("t2_byte1", bs[1], 8'h01);
    chk("t2_level_peak", maxl, 1);
    q = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (ia.tx !== 1'b1) q = 1'b0;
    end
    chk("t2_single_frame", q, 1);
    // four captures two cycles apart; the fourth finds the FIFO full and is dropped
    reset_all();
    fork
      begin
        pulse(11'h100);
        pulse(11'h200);
        pulse(11'h300);
        pulse(11'h7FF);
      end
      for (int i = 0; i < 6; i++) recv(0, 4, bs[i], gs[i]);
    join
    for (int i = 0; i < 6; i++) chk($sformatf("t3_byte%0d", i), bs[i], e3[i]);
    for (int i = 1; i < 6; i++) chk($sformatf("t3_gap%0d", i), gs[i], 1);
    chk("t3_overflow", ia.overflow, 1);
    @(negedge clk);
    chk("t3_end_tx", ia.tx, 1);
    chk("t3_end_busy", ia.busy, 0);
    // push while full on the exact cycle the next entry is popped
    reset_all();
    pulse(11'h0AA);
    pulse(11'h123);
    pulse(11'h456);
    repeat (76) @(negedge clk);
    chk("t4_full_before", ia.level, 2);
    ia.val = 11'h7FF;
    ia.done = 1'b1;
    fork
      begin
        @(negedge clk);
        ia.done = 1'b0;
        chk("t4_level_same", ia.level, 2);
        chk("t4_no_overflow", ia.overflow, 0);
      end
      for (int i = 0; i < 6; i++) recv(0, 4, bs[i], gs[i]);
    join
    for (int i = 0; i < 6; i++) chk($sformatf("t4_byte%0d", i), bs[i], e4[i]);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_gap%0d", i), gs[i], 1);
    // reset at cycle 30 of a frame (data bit 6 of 0xA5 is 0)
    reset_all();
    pulse(11'h5A3);
    @(negedge clk);
    repeat (30) @(negedge clk);
    chk("t5_pre_rst_tx", ia.tx, 0);
    #1 rst = 1'b1;
    #1 chk("t5_async_tx", ia.tx, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_level", ia.level, 0);
    chk("t5_overflow", ia.overflow, 0);
    chk("t5_busy", ia.busy, 0);
    q = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (ia.tx !== 1'b1) q = 1'b0;
    end
    chk("t5_no_resume", q, 1);
    // CLK_DIV=2 and CLK_DIV=16 framing with 0x2C9 -> A2, C9
    reset_all();
    fork
      begin
        @(negedge clk);
        ib.val = 11'h2C9;
        ic.val = 11'h2C9;
        ib.done = 1'b1;
        ic.done = 1'b1;
        @(negedge clk);
        ib.done = 1'b0;
        ic.done = 1'b0;
      end
      begin
        recv(1, 2, cs[0], g);
        recv(1, 2, cs[1], g);
      end
      begin
        recv(2, 16, ds[0], gs[0]);
        recv(2, 16, ds[1], gs[1]);
      end
    join
    chk("div2_byte0", cs[0], 8'hA2);
    chk("div2_byte1", cs[1], 8'hC9);
    chk("div16_byte0", ds[0], 8'hA2);
    chk("div16_byte1", ds[1], 8'hC9);
    chk("div16_gap", gs[1], 1);
    @(negedge clk);
    chk("div2_end_busy", ib.busy, 0);
    chk("div16_end_busy", ic.busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
